// File: rtl/ram_2port_be_if.sv
// Port bundle for ram_2port_be: clear control/status plus two identical access ports.
// Access semantics: an access is issued in any cycle with en=1 while busy=0 (there is no ready);
// val marks the cycle in which do holds that access's result, one pulse per access.
interface ram_2port_be_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 9
);
  localparam int NB = DWIDTH / 8;

  logic              clr;
  logic              busy;
  logic              coll;

  logic              ena;
  logic [NB-1:0]     wea;
  logic [AWIDTH-1:0] addra;
  logic [DWIDTH-1:0] dia;
  logic [DWIDTH-1:0] doa;
  logic              vala;

  logic              enb;
  logic [NB-1:0]     web;
  logic [AWIDTH-1:0] addrb;
  logic [DWIDTH-1:0] dib;
  logic [DWIDTH-1:0] dob;
  logic              valb;

  modport master (
    output clr, ena, wea, addra, dia, enb, web, addrb, dib,
    input  busy, coll, doa, vala, dob, valb
  );

  modport slave (
    input  clr, ena, wea, addra, dia, enb, web, addrb, dib,
    output busy, coll, doa, vala, dob, valb
  );
endinterface

// File: rtl/ram_2port_be.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write,
// optional output register, port-A-wins collision merge and a hardware clear sweep.
module ram_2port_be #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 9,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic            clk,
  input  logic            rst,
  ram_2port_be_if.slave   bus
);
  localparam int NB    = DWIDTH / 8;
  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] caddr_q, caddr_d;
  logic              busy_q, busy_d;

  logic              idle;
  logic              acc_a, acc_b;
  logic [NB-1:0]     wr_a, wr_b;
  logic [DWIDTH-1:0] old_a, old_b;
  logic [DWIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic              va_q, va_d, vb_q, vb_d;
  logic              coll_q, coll_d;

  logic [DWIDTH-1:0] mem [DEPTH];

  function automatic logic [DWIDTH-1:0] merge_bytes(input logic [DWIDTH-1:0] old_w,
                                                    input logic [DWIDTH-1:0] new_w,
                                                    input logic [NB-1:0]     be);
    logic [DWIDTH-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

  // Clear engine: busy is the registered image of being in the sweep.
  always_comb begin
    state_d = state_q;
    caddr_d = caddr_q;
    busy_d  = busy_q;
    case (state_q)
      S_CLEAR: begin
        caddr_d = caddr_q + AWIDTH'(1);
        if (caddr_q == {AWIDTH{1'b1}}) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (bus.clr) begin
          state_d = S_CLEAR;
          caddr_d = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_CLEAR;
        caddr_d = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      caddr_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      caddr_q <= caddr_d;
      busy_q  <= busy_d;
    end
  end

  assign idle  = (state_q == S_IDLE);
  assign acc_a = idle & bus.ena;
  assign acc_b = idle & bus.enb;
  assign wr_a  = acc_a ? bus.wea : '0;
  assign wr_b  = acc_b ? bus.web : '0;

  // Port B lanes are applied first so port A overwrites them on a shared address.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[caddr_q] <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (wr_b[k]) mem[bus.addrb][8*k +: 8] <= bus.dib[8*k +: 8];
      end
      for (int k = 0; k < NB; k++) begin
        if (wr_a[k]) mem[bus.addra][8*k +: 8] <= bus.dia[8*k +: 8];
      end
    end
  end

  // Cross-port reads always see the pre-write word; only the own port's bytes can be forwarded.
  always_comb begin
    old_a  = mem[bus.addra];
    old_b  = mem[bus.addrb];
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (acc_a) rd_a_d = (RDW_MODE != 0) ? merge_bytes(old_a, bus.dia, bus.wea) : old_a;
    if (acc_b) rd_b_d = (RDW_MODE != 0) ? merge_bytes(old_b, bus.dib, bus.web) : old_b;
    va_d   = acc_a;
    vb_d   = acc_b;
    coll_d = acc_a & acc_b & (bus.addra == bus.addrb) & (|bus.wea) & (|bus.web);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
      va_q   <= 1'b0;
      vb_q   <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      va_q   <= va_d;
      vb_q   <= vb_d;
      coll_q <= coll_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.coll = coll_q;

  if (OUT_REG != 0) begin : g_oreg
    logic [DWIDTH-1:0] po_a_q, po_a_d, po_b_q, po_b_d;
    logic              pv_a_q, pv_a_d, pv_b_q, pv_b_d;

    // The second stage only moves when the first stage carries a fresh result.
    always_comb begin
      po_a_d = va_q ? rd_a_q : po_a_q;
      po_b_d = vb_q ? rd_b_q : po_b_q;
      pv_a_d = va_q;
      pv_b_d = vb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        po_a_q <= '0;
        po_b_q <= '0;
        pv_a_q <= 1'b0;
        pv_b_q <= 1'b0;
      end else begin
        po_a_q <= po_a_d;
        po_b_q <= po_b_d;
        pv_a_q <= pv_a_d;
        pv_b_q <= pv_b_d;
      end
    end

    assign bus.doa  = po_a_q;
    assign bus.dob  = po_b_q;
    assign bus.vala = pv_a_q;
    assign bus.valb = pv_b_q;
  end else begin : g_direct
    assign bus.doa  = rd_a_q;
    assign bus.dob  = rd_b_q;
    assign bus.vala = va_q;
    assign bus.valb = vb_q;
  end
endmodule
